stream_window_avg: RTL and testbench

Streaming datapath core that sits directly downstream of the averager AXI4-Lite register slave, which supplies its configuration and reads back its status. It accepts unsigned samples on a valid/ready input stream and accumulates a power-of-two window of them. It then emits one truncated mean per window on a valid/ready output stream. It also counts completed windows for software readback.

---
 rtl/stream_avg_pkg.sv | 18 +
 rtl/avg_accum.sv | 69 ++++++
 rtl/stream_window_avg.sv | 90 +++++++++
 tb/tb_stream_window_avg.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_avg_pkg.sv
// Shared types and helpers for the streaming window averager.
package stream_avg_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

  localparam int DEF_DATA_W       = 32;
  localparam int DEF_MAX_LOG2_WIN = 8;
  localparam int DEF_CNT_W        = 32;
  localparam int ACC_W            = DEF_DATA_W + DEF_MAX_LOG2_WIN;

  function automatic logic [3:0] clamp_log2(input logic [3:0] req, input logic [3:0] lim);
    return (req > lim) ? lim : req;
  endfunction

endpackage

// File: rtl/avg_accum.sv
// Window accumulator: sums samples, counts them and produces the shifted mean on the last one.
// done_o/result_o are combinational from the accepting cycle; window size is frozen at window start.
module avg_accum
  import stream_avg_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MAX_LOG2_WIN = DEF_MAX_LOG2_WIN
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_accum_i,
  input  logic                  clr_i,
  input  logic                  accept_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic [3:0]            cfg_log2_win_i,
  output logic                  done_o,
  output logic [DATA_W-1:0]     result_o,
  output logic [MAX_LOG2_WIN:0] sample_cnt_o
);

  localparam int AW = DATA_W + MAX_LOG2_WIN;
  localparam int CW = MAX_LOG2_WIN + 1;

  logic [AW-1:0] acc_q, acc_d, sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    win_q, win_d;
  logic          last;

  always_comb begin
    sum      = acc_q + AW'(data_i);
    last     = (cnt_q == CW'((CW'(1) << win_q) - CW'(1)));
    done_o   = accept_i & last;
    result_o = DATA_W'(sum >> win_q);
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    // Window size only follows the config between windows.
    if (in_accum_i && (cnt_q == '0)) begin
      win_d = clamp_log2(cfg_log2_win_i, 4'(MAX_LOG2_WIN));
    end
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept_i) begin
      if (last) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
      win_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      win_q <= win_d;
    end
  end

  assign sample_cnt_o = cnt_q;

endmodule

// File: rtl/stream_window_avg.sv
// Streaming power-of-two window mean; result registered one cycle after the last sample.
// Output holds until m_tready; input stalls (s_tready=0) while a result is pending.
module stream_window_avg
  import stream_avg_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MAX_LOG2_WIN = DEF_MAX_LOG2_WIN,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cfg_enable,
  input  logic [3:0]            cfg_log2_win,
  input  logic                  cfg_clear,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_W-1:0]     s_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_W-1:0]     m_tdata,
  output logic [MAX_LOG2_WIN:0] sample_cnt,
  output logic [CNT_W-1:0]      win_count
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic              accept, done;
  logic [DATA_W-1:0] result;

  assign s_tready = ~ARESET & (state_q == ACCUM) & cfg_enable & ~cfg_clear;
  assign accept   = s_tvalid & s_tready;

  avg_accum #(
    .DATA_W       (DATA_W),
    .MAX_LOG2_WIN (MAX_LOG2_WIN)
  ) u_accum (
    .clk_i          (ACLK),
    .rst_i          (ARESET),
    .in_accum_i     (state_q == ACCUM),
    .clr_i          (cfg_clear),
    .accept_i       (accept),
    .data_i         (s_tdata),
    .cfg_log2_win_i (cfg_log2_win),
    .done_o         (done),
    .result_o       (result),
    .sample_cnt_o   (sample_cnt)
  );

  always_comb begin
    state_d = state_q;
    tdata_d = tdata_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ACCUM: begin
        if (done) begin
          state_d = EMIT;
          tdata_d = result;
        end
      end
      EMIT: begin
        // Clear discards the pending result even if the sink is ready.
        if (cfg_clear) begin
          state_d = ACCUM;
        end else if (m_tready) begin
          state_d = ACCUM;
          wcnt_d  = wcnt_q + CNT_W'(1);
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= ACCUM;
      tdata_q <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tdata_q <= tdata_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign m_tvalid  = (state_q == EMIT);
  assign m_tdata   = tdata_q;
  assign win_count = wcnt_q;

endmodule

// File: tb/tb_stream_window_avg.sv
// Directed bench for stream_window_avg with a queue scoreboard and an output monitor.
module tb_stream_window_avg;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cfg_enable;
  logic [3:0]  cfg_log2_win;
  logic        cfg_clear;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] s_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic [8:0]  sample_cnt;
  logic [31:0] win_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  always #5 ACLK = ~ACLK;

  stream_window_avg #(.DATA_W(32), .MAX_LOG2_WIN(8), .CNT_W(32)) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .cfg_enable   (cfg_enable),
    .cfg_log2_win (cfg_log2_win),
    .cfg_clear    (cfg_clear),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tdata      (s_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tdata      (m_tdata),
    .sample_cnt   (sample_cnt),
    .win_count    (win_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  // Present one sample and hold it until the DUT accepts it.
  task automatic send(input logic [31:0] d);
    int t = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    @(negedge ACLK);
    while (!s_tready && t < 1000) begin
      @(negedge ACLK);
      t++;
    end
    if (!s_tready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: s_tready stayed 0 for data 0x%0h", d);
      s_tvalid = 1'b0;
    end else begin
      @(posedge ACLK);
      #1;
      s_tvalid = 1'b0;
    end
  endtask

  task automatic set_win(input logic [3:0] l);
    cfg_log2_win = l;
    idle(2);
  endtask

  // Monitor: every output handshake must match the head of the scoreboard.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge ACLK);
      if (ARESET === 1'b0 && cfg_clear === 1'b0 && m_tvalid === 1'b1 && m_tready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got 0x%0h with no result expected", m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", {32'h0, m_tdata}, {32'h0, e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1; cfg_enable = 1'b1; cfg_log2_win = 4'd2; cfg_clear = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
    idle(3);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_sample_cnt", sample_cnt, 0);
    chk("rst_win_count", win_count, 0);
    ARESET = 1'b0;
    idle(2);

    // N=4: 1+2+3+4 = 10 -> 2
    exp_q.push_back(32'd2);
    send(1); send(2); send(3); send(4);
    chk("t1_latency_vld", m_tvalid, 1);
    chk("t1_data", m_tdata, 2);
    chk("t1_s_tready_emit", s_tready, 0);
    idle(1);
    chk("t1_vld_drop", m_tvalid, 0);
    chk("t1_win_count", win_count, 1);

    // N=256 of all-ones, then requested 15 clamps to 8
    set_win(4'd8);
    exp_q.push_back(32'hFFFF_FFFF);
    for (int i = 0; i < 256; i++) send(32'hFFFF_FFFF);
    chk("t2_max_vld", m_tvalid, 1);
    chk("t2_max_data", m_tdata, 32'hFFFF_FFFF);
    idle(1);
    set_win(4'd15);
    exp_q.push_back(32'd127);
    for (int i = 0; i < 255; i++) send(32'(i));
    chk("t2_clamp_not_early", m_tvalid, 0);
    send(32'd255);
    chk("t2_clamp_vld", m_tvalid, 1);
    chk("t2_clamp_data", m_tdata, 127);
    idle(1);
    chk("t2_win_count", win_count, 3);

    // Backpressure: N=2, (7+9)/2 = 8 held for 5 cycles
    set_win(4'd1);
    m_tready = 1'b0;
    exp_q.push_back(32'd8);
    send(7); send(9);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_vld", m_tvalid, 1);
      chk("t3_hold_data", m_tdata, 8);
      chk("t3_hold_s_tready", s_tready, 0);
      idle(1);
    end
    m_tready = 1'b1;
    idle(1);
    chk("t3_release_vld", m_tvalid, 0);
    chk("t3_release_s_tready", s_tready, 1);
    chk("t3_win_count", win_count, 4);

    // Clear discards a partial window; sample offered during clear is refused
    set_win(4'd2);
    send(100); send(100);
    chk("t4_partial_cnt", sample_cnt, 2);
    cfg_clear = 1'b1; s_tvalid = 1'b1; s_tdata = 32'd999;
    #1;
    chk("t4_clear_s_tready", s_tready, 0);
    idle(1);
    cfg_clear = 1'b0; s_tvalid = 1'b0;
    chk("t4_clear_cnt", sample_cnt, 0);
    exp_q.push_back(32'd4);
    send(4); send(4); send(4); send(4);
    chk("t4_clear_vld", m_tvalid, 1);
    idle(1);

    // Enable dropped mid-window holds the partial sum: (10+20+30+40)/4 = 25
    send(10); send(20);
    cfg_enable = 1'b0; s_tvalid = 1'b1; s_tdata = 32'd99;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (i == 0 || i == 9) begin
        chk("t4_dis_s_tready", s_tready, 0);
        chk("t4_dis_cnt", sample_cnt, 2);
      end
      idle(1);
    end
    s_tvalid = 1'b0; cfg_enable = 1'b1;
    exp_q.push_back(32'd25);
    send(30); send(40);
    chk("t4_resume_vld", m_tvalid, 1);
    idle(1);

    // Window change mid-window: still N=4, (8+8+16+8)/4 = 10
    send(8);
    cfg_log2_win = 4'd1;
    send(8); send(16);
    chk("t4_oldwin_not_early", m_tvalid, 0);
    exp_q.push_back(32'd10);
    send(8);
    chk("t4_oldwin_vld", m_tvalid, 1);
    idle(1);
    chk("t4_win_count", win_count, 7);

    // Pass-through N=1
    set_win(4'd0);
    exp_q.push_back(32'h1234);
    send(32'h1234);
    chk("t5_pass_vld", m_tvalid, 1);
    chk("t5_pass_data", m_tdata, 32'h1234);
    chk("t5_pass_bubble", s_tready, 0);
    idle(1);
    chk("t5_pass_done", m_tvalid, 0);

    // Clear beats a simultaneous m_tready in EMIT
    m_tready = 1'b0;
    send(32'd3);
    chk("t5_emit_vld", m_tvalid, 1);
    cfg_clear = 1'b1; m_tready = 1'b1;
    idle(1);
    cfg_clear = 1'b0;
    chk("t5_clear_emit_vld", m_tvalid, 0);
    chk("t5_clear_emit_wc", win_count, 8);

    // Reset with a partial window, then with a pending result
    set_win(4'd2);
    send(1); send(2); send(3);
    chk("t6_partial_cnt", sample_cnt, 3);
    ARESET = 1'b1;
    #1;
    chk("t6_rst_s_tready", s_tready, 0);
    idle(1);
    chk("t6_rst_cnt", sample_cnt, 0);
    chk("t6_rst_wc", win_count, 0);
    ARESET = 1'b0;
    idle(3);
    m_tready = 1'b0;
    send(5); send(5); send(5); send(5);
    chk("t6_pending_vld", m_tvalid, 1);
    ARESET = 1'b1; m_tready = 1'b1;
    idle(1);
    chk("t6_rst2_vld", m_tvalid, 0);
    chk("t6_rst2_data", m_tdata, 0);
    chk("t6_rst2_cnt", sample_cnt, 0);
    chk("t6_rst2_wc", win_count, 0);
    ARESET = 1'b0;
    idle(20);
    chk("t6_no_beat_vld", m_tvalid, 0);
    chk("end_scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
